// File: rtl/qpp_data_permuter.sv
// QPP data permuter: buffers one block in natural order, then
// replays it in the order given by the QPP index generator.
module qpp_data_permuter #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 13,
    parameter int MAX_VALUE    = 20,
    parameter int K_MAX        = 6144
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COUNT_WIDTH-1:0]  K,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic                    data_valid_in,
    output logic                    ready_out,
    output logic                    start_out,
    input  logic [MAX_VALUE-1:0]    index_in,
    input  logic                    index_valid_in,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    output logic                    data_valid_out,
    output logic                    data_last_out,
    output logic                    err_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PERMUTE
    } state_t;

    localparam int DEPTH = 1 << COUNT_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] KMAX_C = COUNT_WIDTH'(K_MAX);
    localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  k_reg;
    logic [COUNT_WIDTH-1:0]  wr_cnt;
    logic [COUNT_WIDTH-1:0]  rd_cnt;
    logic [COUNT_WIDTH-1:0]  wr_nxt;
    logic [COUNT_WIDTH-1:0]  rd_nxt;
    logic [COUNT_WIDTH-1:0]  wr_addr;
    logic [COUNT_WIDTH-1:0]  rd_addr;
    logic [SAMPLE_WIDTH-1:0] mem [0:DEPTH-1];
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    rd_ok;
    logic                    k_ok;
    logic                    wr_en;
    logic                    rd_en;
    logic                    rd_hit;

    // Decode buffer accesses for the current state; nothing moves in reset
    always_comb begin
        k_ok    = (K != '0) && (K <= KMAX_C);
        wr_nxt  = wr_cnt + ONE;
        rd_nxt  = rd_cnt + ONE;
        wr_en   = 1'b0;
        wr_addr = wr_cnt;
        rd_en   = 1'b0;
        rd_addr = index_in[COUNT_WIDTH-1:0];
        rd_hit  = index_in < MAX_VALUE'(k_reg);
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (data_valid_in && k_ok) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                    end
                end
                LOAD:    wr_en = data_valid_in;
                PERMUTE: rd_en = index_valid_in;
                default: ;
            endcase
        end
    end

    // Write port of the sample buffer (contents are never reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Read port of the sample buffer, one cycle latency
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Out-of-range or idle reads present zero instead of stale RAM data
    assign data_out = rd_ok ? rd_data : '0;

    // Block sequencing FSM with registered handshake and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            k_reg          <= '0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            ready_out      <= 1'b1;
            start_out      <= 1'b0;
            data_valid_out <= 1'b0;
            data_last_out  <= 1'b0;
            rd_ok          <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            start_out      <= 1'b0;
            data_valid_out <= rd_en;
            data_last_out  <= 1'b0;
            rd_ok          <= rd_en && rd_hit;
            unique case (state)
                IDLE: begin
                    if (index_valid_in) begin
                        err_out <= 1'b1;
                    end
                    if (data_valid_in) begin
                        if (k_ok) begin
                            k_reg  <= K;
                            wr_cnt <= ONE;
                            if (K == ONE) begin
                                state     <= PERMUTE;
                                start_out <= 1'b1;
                                ready_out <= 1'b0;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (index_valid_in) begin
                        err_out <= 1'b1;
                    end
                    if (data_valid_in) begin
                        wr_cnt <= wr_nxt;
                        if (wr_nxt == k_reg) begin
                            state     <= PERMUTE;
                            start_out <= 1'b1;
                            ready_out <= 1'b0;
                        end
                    end
                end
                PERMUTE: begin
                    if (data_valid_in) begin
                        err_out <= 1'b1;
                    end
                    if (index_valid_in) begin
                        rd_cnt <= rd_nxt;
                        if (!rd_hit) begin
                            err_out <= 1'b1;
                        end
                        if (rd_nxt == k_reg) begin
                            data_last_out <= 1'b1;
                            state         <= IDLE;
                            ready_out     <= 1'b1;
                            rd_cnt        <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/qpp_data_permuter.md
QPP_DATA_PERMUTER -- requirements
Module: qpp_data_permuter

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8: width of one soft sample.
REQ-002 SHALL have parameter COUNT_WIDTH, default 13: block-length and address width. This equals clog2(5952) and gives a buffer depth of 2^COUNT_WIDTH.
REQ-003 SHALL have parameter MAX_VALUE, default 20: width of the incoming index, matching the index generator's index_out.
REQ-004 SHALL have parameter K_MAX, default 6144: the largest legal block length.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port K, input, COUNT_WIDTH: block length, sampled at block start.
REQ-008 SHALL have port data_in, input, SAMPLE_WIDTH: sample in natural order.
REQ-009 SHALL have port data_valid_in, input, 1: data_in qualifier.
REQ-010 SHALL have port ready_out, output, 1: high while the block accepts samples.
REQ-011 SHALL have port start_out, output, 1: one-cycle pulse that drives the index generator's valid_in.
REQ-012 SHALL have port index_in, input, MAX_VALUE: interleaved index from the index generator's index_out.
REQ-013 SHALL have port index_valid_in, input, 1: qualifier from the index generator's index_valid_out.
REQ-014 SHALL have port data_out, output, SAMPLE_WIDTH: permuted sample.
REQ-015 SHALL have port data_valid_out, output, 1: data_out qualifier.
REQ-016 SHALL have port data_last_out, output, 1: high with the K-th output of a block.
REQ-017 SHALL have port err_out, output, 1: sticky protocol/range error.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, PERMUTE.
REQ-019 In IDLE, ready_out SHALL be 1; a cycle with data_valid_in=1 SHALL latch K into k_reg, write data_in to address 0, set wr_cnt=1 and go to LOAD.
REQ-020 In IDLE, if K=0 or K>K_MAX when data_valid_in=1, the sample SHALL be dropped, err_out SHALL be set, and the FSM SHALL stay in IDLE.
REQ-021 If k_reg=1, the FSM SHALL bypass LOAD and go straight to PERMUTE, with start_out pulsing in the same cycle.
REQ-022 In LOAD, ready_out SHALL be 1; each data_valid_in SHALL write data_in to address wr_cnt and increment wr_cnt. Gaps in data_valid_in are allowed.
REQ-023 The write that makes wr_cnt=k_reg SHALL pulse start_out for exactly one cycle, coincident with the FSM entering PERMUTE. ready_out SHALL drop the following cycle.
REQ-024 In PERMUTE, each index_valid_in SHALL issue a buffer read at address index_in[COUNT_WIDTH-1:0] and increment rd_cnt.
REQ-025 Read latency SHALL be exactly 1 cycle: data_valid_out SHALL assert the cycle after index_valid_in, with data_out equal to the sample written at that index.
REQ-026 Indices may arrive back-to-back on every cycle; there SHALL be no backpressure on the index stream.
REQ-027 If index_in>=k_reg, data_out SHALL be 0 with data_valid_out still asserted, and err_out SHALL be set.
REQ-028 data_last_out SHALL assert with the output whose read made rd_cnt=k_reg. The FSM SHALL return to IDLE on the same edge as that read, and ready_out SHALL be 1 on the next cycle.
REQ-029 A new block MAY start in the cycle data_last_out is high. The buffer read for the last sample has already completed, so a new write cannot corrupt it.
REQ-030 data_valid_in during PERMUTE SHALL be ignored (no write) and SHALL set err_out.
REQ-031 index_valid_in in IDLE or LOAD SHALL be ignored (no output) and SHALL set err_out.
REQ-032 Counters SHALL be COUNT_WIDTH bits and SHALL never wrap, because the FSM leaves LOAD/PERMUTE at k_reg.
REQ-033 The buffer SHALL be a single-port-per-side inferred RAM (write port plus read port), depth 2^COUNT_WIDTH, with no reset of its contents.
REQ-034 err_out SHALL clear only on rst.

Reset
REQ-035 When rst=1 at a clock edge, the FSM SHALL go to IDLE and wr_cnt, rd_cnt and k_reg SHALL clear to 0.
REQ-036 On reset, data_valid_out, data_last_out, start_out and err_out SHALL be 0, data_out SHALL be 0, and ready_out SHALL be 1 from the first cycle after reset.
REQ-037 Reset in the middle of LOAD or PERMUTE SHALL abandon the block without a data_last_out. Any index_valid_in seen while rst=1 SHALL produce no output.

Verification
REQ-038 K=40, data_in=i for i=0..39, with the generator driven by f1=3, f2=10 -> start_out pulses once after the 40th write. Outputs are 0, 13, 6, 19, ... (value = (3i+10i^2) mod 40), with the 40th output 7 and data_last_out=1 on it only; err_out=0.
REQ-039 K=160, f1=21, f2=120, data_in=random, with a gap of 3 idle cycles after every 7th sample -> every output equals stored[(21i+120i^2) mod 160] exactly 1 cycle after its index.
REQ-040 K=5952, f1=47, f2=186, indices back-to-back -> 5952 consecutive data_valid_out cycles, last one flagged, then ready_out=1.
REQ-041 K=0, then K=6145 offered in IDLE -> no writes, FSM stays in IDLE, err_out=1.
REQ-042 index_in=45 during PERMUTE with K=40 -> data_out=0, data_valid_out=1, err_out=1.
REQ-043 rst asserted after 20 of 40 outputs -> all outputs 0 next cycle, ready_out=1, and a following K=40 block completes correctly.
